// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Purpose  : Fixed-latency instruction memory read responder with ISP writes.
// Revision : 1.0  initial release
// ============================================================================
module imem_responder #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int INDEX_BITS   = 8,
  parameter int LATENCY      = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDRESS_BITS-1:0] read_address,
  input  logic [ADDRESS_BITS-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [ADDRESS_BITS-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    valid,
  output logic                    ready,
  input  logic                    report
);

  localparam int c_DEPTH = 1 << INDEX_BITS;

  logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];
  logic [LATENCY-1:0]      r_pipe_valid;
  logic [ADDRESS_BITS-1:0] r_pipe_addr [LATENCY];
  logic [DATA_WIDTH-1:0]   r_pipe_data [LATENCY];
  logic                    r_valid;
  logic [ADDRESS_BITS-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [31:0]             r_cycle;

  logic                    w_accept;
  logic [INDEX_BITS-1:0]   w_read_index;
  logic [INDEX_BITS-1:0]   w_write_index;

  // Writes own the array port for the cycle, so a concurrent read is refused.
  assign ready         = !reset && !write;
  assign w_accept      = read && ready;
  assign w_read_index  = read_address[INDEX_BITS-1:0];
  assign w_write_index = write_address[INDEX_BITS-1:0];

  assign valid    = r_valid;
  assign out_addr = r_out_addr;
  assign out_data = r_out_data;

  // Array has no reset so an ISP-loaded program survives a core reset.
  always_ff @(posedge clock) begin
    if (write) begin
      r_mem[w_write_index] <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe_addr[i] <= '0;
        r_pipe_data[i] <= '0;
      end
      r_valid    <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_pipe_valid[0] <= w_accept;
      if (w_accept) begin
        r_pipe_addr[0] <= read_address;
        r_pipe_data[0] <= r_mem[w_read_index];
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_addr[i]  <= r_pipe_addr[i-1];
        r_pipe_data[i]  <= r_pipe_data[i-1];
      end
      // Output registers hold the last response while idle.
      r_valid <= r_pipe_valid[LATENCY-1];
      if (r_pipe_valid[LATENCY-1]) begin
        r_out_addr <= r_pipe_addr[LATENCY-1];
        r_out_data <= r_pipe_data[LATENCY-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  generate
    if (ADDRESS_BITS > INDEX_BITS) begin : g_addr_upper
      logic w_unused_upper;
      assign w_unused_upper = ^write_address[ADDRESS_BITS-1:INDEX_BITS];
    end
  endgenerate

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report) begin
      $display("imem core %0d cyc %0d rd %b wr %b rdy %b vld %b addr %h data %h pipe %b",
               CORE, r_cycle, read, write, ready, r_valid, r_out_addr, r_out_data,
               r_pipe_valid);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_responder
// Purpose  : Bench driving LATENCY 1/2/4 responders with shared directed stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_responder;

  localparam logic [2:0] c_LATS [3] = '{3'd1, 3'd2, 3'd4};

  logic        clock = 1'b0;
  logic        reset, read, write, report;
  logic [19:0] read_address, write_address;
  logic [31:0] in_data;

  logic [2:0]  dv, dr;
  logic [19:0] da [3];
  logic [31:0] dd [3];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  imem_responder #(.CORE(0), .LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .read_address(read_address), .write_address(write_address), .in_data(in_data),
    .out_addr(da[0]), .out_data(dd[0]), .valid(dv[0]), .ready(dr[0]), .report(report));

  imem_responder #(.CORE(1), .LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .read_address(read_address), .write_address(write_address), .in_data(in_data),
    .out_addr(da[1]), .out_data(dd[1]), .valid(dv[1]), .ready(dr[1]), .report(report));

  imem_responder #(.CORE(2), .LATENCY(4)) u_l4 (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .read_address(read_address), .write_address(write_address), .in_data(in_data),
    .out_addr(da[2]), .out_data(dd[2]), .valid(dv[2]), .ready(dr[2]), .report(report));

  // Model: responses are scheduled into a slot ring keyed by due cycle.
  logic [31:0] m_mem [256];
  bit          sv [3][8];
  logic [19:0] sa [3][8];
  logic [31:0] sd [3][8];
  bit          ev [3];
  logic [19:0] ea [3];
  logic [31:0] ed [3];
  logic [31:0] cyc = '0;
  bit          m_live = 1'b0;
  logic [2:0]  slot, due;

  always @(posedge clock) begin
    slot = cyc[2:0];
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        for (int s = 0; s < 8; s++) sv[i][s] = 1'b0;
        ev[i] = 1'b0;
        ea[i] = '0;
        ed[i] = '0;
      end else begin
        ev[i] = sv[i][slot];
        if (sv[i][slot]) begin
          ea[i] = sa[i][slot];
          ed[i] = sd[i][slot];
          sv[i][slot] = 1'b0;
        end
        if (read && !write) begin
          due = slot + c_LATS[i];
          sv[i][due] = 1'b1;
          sa[i][due] = read_address;
          sd[i][due] = m_mem[read_address[7:0]];
        end
      end
    end
    if (write) m_mem[write_address[7:0]] = in_data;
    if (reset) m_live = 1'b1;
    cyc = cyc + 32'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (m_live) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("L%0d valid", c_LATS[i]), {31'b0, dv[i]}, {31'b0, ev[i]});
        chk($sformatf("L%0d out_addr", c_LATS[i]), {12'b0, da[i]}, {12'b0, ea[i]});
        chk($sformatf("L%0d out_data", c_LATS[i]), dd[i], ed[i]);
        chk($sformatf("L%0d ready", c_LATS[i]), {31'b0, dr[i]}, {31'b0, (!reset && !write)});
      end
    end
  end

  task automatic step(input logic rst_i, input logic rd, input logic [19:0] ra,
                      input logic wr, input logic [19:0] wa, input logic [31:0] wd);
    @(negedge clock);
    reset = rst_i; read = rd; read_address = ra;
    write = wr; write_address = wa; in_data = wd;
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 32'h0);
  endtask

  logic [31:0] c_stream [4] = '{32'h13, 32'h93, 32'h113, 32'h6F};
  logic        seen;

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; report = 1'b0;
    read_address = '0; write_address = '0; in_data = '0;
    repeat (3) @(posedge clock);
    #2;
    chk("reset valid", {29'b0, dv}, 32'h0);
    chk("reset out_data L2", dd[1], 32'h0);
    chk("reset out_addr L4", {12'b0, da[2]}, 32'h0);

    // Latency check
    step(1'b0, 1'b0, 20'h0, 1'b1, 20'h10, 32'hDEADBEEF);
    step(1'b0, 1'b1, 20'h10, 1'b0, 20'h0, 32'h0);
    chk("lat accept-edge valid", {29'b0, dv}, 32'h0);
    idle();
    chk("lat1 valid", {31'b0, dv[0]}, 32'h1);
    chk("lat1 data", dd[0], 32'hDEADBEEF);
    chk("lat2 early valid", {31'b0, dv[1]}, 32'h0);
    idle();
    chk("lat2 valid", {31'b0, dv[1]}, 32'h1);
    chk("lat2 addr", {12'b0, da[1]}, 32'h10);
    chk("lat2 data", dd[1], 32'hDEADBEEF);
    chk("lat1 one-shot", {31'b0, dv[0]}, 32'h0);
    idle();
    chk("lat2 drop", {31'b0, dv[1]}, 32'h0);
    chk("lat2 hold", dd[1], 32'hDEADBEEF);
    idle();
    chk("lat4 valid", {31'b0, dv[2]}, 32'h1);
    chk("lat4 data", dd[2], 32'hDEADBEEF);
    idle();

    // Streaming
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 20'h0, 1'b1, 20'(i), c_stream[i]);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 20'(i), 1'b0, 20'h0, 32'h0);
    chk("stream L2 2nd addr", {12'b0, da[1]}, 32'h1);
    chk("stream L2 2nd data", dd[1], 32'h93);
    idle();
    chk("stream L4 1st data", dd[2], 32'h13);
    chk("stream L4 1st valid", {31'b0, dv[2]}, 32'h1);
    chk("stream L1 last data", dd[0], 32'h6F);
    repeat (4) idle();

    // Write priority
    step(1'b0, 1'b1, 20'h5, 1'b1, 20'h5, 32'hAAAA5555);
    chk("collision ready", {29'b0, dr}, 32'h0);
    step(1'b0, 1'b1, 20'h5, 1'b0, 20'h0, 32'h0);
    chk("collision not accepted", {31'b0, dv[0]}, 32'h0);
    idle();
    chk("retry L1 valid", {31'b0, dv[0]}, 32'h1);
    chk("retry L1 data", dd[0], 32'hAAAA5555);
    repeat (4) idle();

    // Address wrap
    step(1'b0, 1'b0, 20'h0, 1'b1, 20'h004, 32'h12345678);
    step(1'b0, 1'b1, 20'h104, 1'b0, 20'h0, 32'h0);
    idle();
    idle();
    chk("wrap L2 valid", {31'b0, dv[1]}, 32'h1);
    chk("wrap L2 addr", {12'b0, da[1]}, 32'h104);
    chk("wrap L2 data", dd[1], 32'h12345678);
    step(1'b0, 1'b1, 20'hABC04, 1'b0, 20'h0, 32'h0);
    repeat (5) idle();

    // Reset in flight
    step(1'b0, 1'b1, 20'h10, 1'b0, 20'h0, 32'h0);
    step(1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 32'h0);
    chk("rst valid", {29'b0, dv}, 32'h0);
    chk("rst L1 data", dd[0], 32'h0);
    chk("rst L4 data", dd[2], 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle();
      seen = seen | (|dv);
    end
    chk("rst no stale valid", {31'b0, seen}, 32'h0);
    step(1'b0, 1'b1, 20'h10, 1'b0, 20'h0, 32'h0);
    idle();
    idle();
    chk("post-rst L2 data", dd[1], 32'hDEADBEEF);
    repeat (4) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
